// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and helpers for the BCD stopwatch controller.
// Holds the control FSM state encoding and the single-digit BCD increment.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

  // Returns {carry, next_digit}. Anything at or above 9 rolls to 0, so a digit can never leave 0-9.
  function automatic logic [DIGIT_W:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    if (d >= BCD_MAX) begin
      return {1'b1, {DIGIT_W{1'b0}}};
    end
    return {1'b0, d + DIGIT_W'(1)};
  endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_button_debounce.sv
// Two-flop synchronizer, stability-count debouncer and press pulse for one raw button.
// The pulse fires DB_CYCLES+3 cycles after a clean raw rising edge; releases give no pulse.
module button_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;

      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons, RUN/PAUSE/IDLE FSM,
// tick prescaler and two-digit BCD count feeding the seven-segment display stage.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | count held at 00, prescaler cleared, waiting for start
//   ST_RUN   | prescaler advancing, digits increment on every tick
//   ST_PAUSE | count and prescaler frozen; start resumes, clear -> IDLE
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 10000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  output logic [DIGIT_W-1:0] first,
  output logic [DIGIT_W-1:0] second,
  output logic               running,
  output logic               wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t           state;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             ss_level;
  logic             ss_press;
  logic             clr_level;
  logic             clr_press;
  logic [DIGIT_W:0] ones_inc;
  logic [DIGIT_W:0] tens_inc;
  logic             unused_levels;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start_stop (
    .clock  (clock),
    .reset  (reset),
    .btn_in (btn_start_stop),
    .level  (ss_level),
    .press  (ss_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clock  (clock),
    .reset  (reset),
    .btn_in (btn_clear),
    .level  (clr_level),
    .press  (clr_press)
  );

  // Only the press pulses drive the FSM; the steady levels are not needed here.
  assign unused_levels = ss_level ^ clr_level;

  assign tick     = (state == ST_RUN) && (presc == PRESC_LAST);
  assign ones_inc = bcd_inc(first);
  assign tens_inc = bcd_inc(second);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      presc   <= '0;
      first   <= '0;
      second  <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          presc <= '0;
          if (ss_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            first <= ones_inc[DIGIT_W-1:0];
            if (ones_inc[DIGIT_W]) begin
              second <= tens_inc[DIGIT_W-1:0];
              wrap   <= tens_inc[DIGIT_W];
            end
          end
          // A tick landing with the stop press still counts before pausing.
          if (ss_press) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end

        ST_PAUSE: begin
          if (clr_press) begin
            state  <= ST_IDLE;
            presc  <= '0;
            first  <= '0;
            second <= '0;
          end else if (ss_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: directed vector table, hand-written corner sequences and
// random button traffic, all checked against a run-time based reference model.
module tb_bcd_stopwatch_ctrl;

  localparam int TD  = 4;
  localparam int DB  = 3;
  localparam int LAT = DB + 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [3:0] first;
  logic [3:0] second;
  logic       running;
  logic       wrap;

  bcd_stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .first          (first),
    .second         (second),
    .running        (running),
    .wrap           (wrap)
  );

  always #5 clock = ~clock;

  int total    = 0;
  int bad      = 0;
  int edge_cnt = 0;

  // Reference: count = floor(cycles spent in RUN since last clear / TD) mod 100.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
  mstate_t m_st    = M_IDLE;
  int      run_cyc = 0;
  bit      m_wrap  = 1'b0;
  int      ss_q[$];
  int      clr_q[$];

  typedef struct {
    logic       ss;
    logic       clr;
    int         len;
    logic       exp_run;
    logic [3:0] exp_first;
    logic [3:0] exp_second;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic model_edge();
    bit ss_ev  = 1'b0;
    bit clr_ev = 1'b0;
    while (ss_q.size() > 0 && ss_q[0] == edge_cnt) begin
      ss_ev = 1'b1;
      void'(ss_q.pop_front());
    end
    while (clr_q.size() > 0 && clr_q[0] == edge_cnt) begin
      clr_ev = 1'b1;
      void'(clr_q.pop_front());
    end
    m_wrap = 1'b0;
    if (m_st == M_RUN) begin
      run_cyc++;
      if (run_cyc % (TD * 100) == 0) m_wrap = 1'b1;
    end
    case (m_st)
      M_IDLE:  if (ss_ev) m_st = M_RUN;
      M_RUN:   if (ss_ev) m_st = M_PAUSE;
      M_PAUSE: begin
        if (clr_ev) begin
          m_st    = M_IDLE;
          run_cyc = 0;
        end else if (ss_ev) begin
          m_st = M_RUN;
        end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic step();
    logic [3:0] ef;
    logic [3:0] es;
    @(posedge clock);
    edge_cnt++;
    model_edge();
    #1;
    ef = 4'((run_cyc / TD) % 10);
    es = 4'((run_cyc / TD / 10) % 10);
    chk("model_cycle", {first, second, running, wrap},
        {ef, es, (m_st == M_RUN) ? 1'b1 : 1'b0, m_wrap});
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    m_st    = M_IDLE;
    run_cyc = 0;
    m_wrap  = 1'b0;
    ss_q.delete();
    clr_q.delete();
    #1;
    chk("rst_first", first, 0);
    chk("rst_second", second, 0);
    chk("rst_running", running, 0);
    chk("rst_wrap", wrap, 0);
    #1 reset = 1'b0;
  endtask

  // Raise buttons now, hold for 'hold' cycles, then release for 'gap' cycles.
  task automatic press(input logic ss, input logic clr, input int hold, input int gap);
    btn_start_stop = ss;
    btn_clear      = clr;
    if (ss)  ss_q.push_back(edge_cnt + LAT);
    if (clr) clr_q.push_back(edge_cnt + LAT);
    repeat (hold) step();
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 20, 1'b1, 4'd3, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 20, 1'b1, 4'd8, 4'd0};
    vecs[2] = '{1'b1, 1'b0, 12, 1'b0, 4'd0, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 13, 1'b1, 4'd1, 4'd1};
    vecs[4] = '{1'b1, 1'b0,  9, 1'b0, 4'd3, 4'd1};
    vecs[5] = '{1'b1, 1'b0, 10, 1'b1, 4'd4, 4'd1};
    vecs[6] = '{1'b1, 1'b0,  8, 1'b0, 4'd5, 4'd1};
    vecs[7] = '{1'b1, 1'b1, 12, 1'b0, 4'd0, 4'd0};
    vecs[8] = '{1'b0, 1'b1, 10, 1'b0, 4'd0, 4'd0};
    vecs[9] = '{1'b1, 1'b0, 10, 1'b1, 4'd0, 4'd0};

    reset          = 1'b1;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    #1;
    chk("init_first", first, 0);
    chk("init_second", second, 0);
    chk("init_running", running, 0);
    chk("init_wrap", wrap, 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();

    // Short glitch must be rejected, a long hold must give exactly one press.
    btn_start_stop = 1'b1;
    repeat (2) step();
    btn_start_stop = 1'b0;
    repeat (10) step();
    chk("glitch_running", running, 0);

    btn_start_stop = 1'b1;
    ss_q.push_back(edge_cnt + LAT);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == LAT - 1) chk("press_before_lat", running, 0);
      if (k == LAT)     chk("press_at_lat", running, 1);
    end
    btn_start_stop = 1'b0;
    repeat (8) step();
    chk("single_press_running", running, 1);

    // Vector table: each row is one press, then len cycles from the raw edge.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(vecs[i].ss, vecs[i].clr, 6, vecs[i].len - 6);
      chk($sformatf("vec%0d_running", i), running, vecs[i].exp_run);
      chk($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
      chk($sformatf("vec%0d_second", i), second, vecs[i].exp_second);
    end

    // 99 -> 00 rollover.
    do_reset();
    press(1'b1, 1'b0, 5, 401);
    chk("pre_wrap_first", first, 9);
    chk("pre_wrap_second", second, 9);
    chk("pre_wrap_flag", wrap, 0);
    step();
    chk("wrap_flag", wrap, 1);
    chk("wrap_first", first, 0);
    chk("wrap_second", second, 0);
    chk("wrap_running", running, 1);
    step();
    chk("post_wrap_flag", wrap, 0);
    chk("post_wrap_first", first, 0);

    // Asynchronous reset while counting at 37.
    do_reset();
    press(1'b1, 1'b0, 5, 150);
    chk("mid_first", first, 7);
    chk("mid_second", second, 3);
    chk("mid_running", running, 1);
    do_reset();
    repeat (3) step();

    for (int n = 0; n < 60; n++) begin
      int   sel;
      int   hold;
      int   gap;
      logic ss;
      logic clr;
      sel  = int'($urandom_range(0, 99));
      ss   = (sel < 60) || (sel >= 85);
      clr  = (sel >= 60);
      hold = int'($urandom_range(3, 8));
      if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(100, 420));
      else                           gap = int'($urandom_range(6, 40));
      press(ss, clr, hold, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
